// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO width helpers and depth check
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // One extra bit so a full FIFO (level == DEPTH) is representable
  function automatic int level_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - WIDTH x DEPTH storage, synchronous write, asynchronous read
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised synchronous FIFO with thresholds, sticky errors, flush and FWFT
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [level_w(DEPTH)-1:0] level,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = level_w(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
  end

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem_rdata;
  logic             wr_acc;
  logic             rd_acc;

  assign full         = (level == LW'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= LW'(AF_LEVEL));
  assign almost_empty = (level <= LW'(AE_LEVEL));

  // A flush cycle accepts nothing, so memory is not written either
  assign wr_acc = wr_en & ~full & ~clear;
  assign rd_acc = rd_en & ~empty & ~clear;

  fifo_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word shown directly; zero while empty so stale memory never leaks out
    assign rd_valid = ~empty;
    assign rd_data  = empty ? '0 : mem_rdata;
  end else begin : g_reg_read
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else if (clear) begin
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param in both read modes
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clear = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_en = 1'b0;

  logic [WIDTH-1:0] rd_data0, rd_data1;
  logic             rd_valid0, rd_valid1, full0, full1, empty0, empty1;
  logic             af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
  logic [LW-1:0]    level0, level1;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue plus the registered-read output state
  logic [WIDTH-1:0] q[$];
  logic             m_ovf, m_unf, m_rv;
  logic [WIDTH-1:0] m_rd;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0),
    .empty(empty0), .almost_full(af0), .almost_empty(ae0), .level(level0),
    .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1),
    .empty(empty1), .almost_full(af1), .almost_empty(ae1), .level(level1),
    .overflow(ovf1), .underflow(unf1)
  );

  typedef struct {
    logic             wr;
    logic [WIDTH-1:0] wd;
    logic             rd;
    logic             clr;
    int               exp_level;
    logic             exp_empty;
    logic             exp_ovf;
    logic             exp_unf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rv  = 1'b0;
    m_rd  = '0;
  endtask

  task automatic model_step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c);
    int sz;
    sz = q.size();
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
    end else begin
      if (w && sz == DEPTH) m_ovf = 1'b1;
      if (r && sz == 0)     m_unf = 1'b1;
      m_rv = 1'b0;
      if (r && sz != 0) begin
        m_rd = q.pop_front();
        m_rv = 1'b1;
      end
      if (w && sz != DEPTH) q.push_back(d);
    end
  endtask

  task automatic check_model();
    int sz;
    sz = q.size();
    chk("level0", 32'(level0), 32'(sz));
    chk("level1", 32'(level1), 32'(sz));
    chk("full0",  32'(full0),  32'(sz == DEPTH));
    chk("full1",  32'(full1),  32'(sz == DEPTH));
    chk("empty0", 32'(empty0), 32'(sz == 0));
    chk("empty1", 32'(empty1), 32'(sz == 0));
    chk("af0",    32'(af0),    32'(sz >= DEPTH - 2));
    chk("af1",    32'(af1),    32'(sz >= DEPTH - 2));
    chk("ae0",    32'(ae0),    32'(sz <= 2));
    chk("ae1",    32'(ae1),    32'(sz <= 2));
    chk("ovf0",   32'(ovf0),   32'(m_ovf));
    chk("ovf1",   32'(ovf1),   32'(m_ovf));
    chk("unf0",   32'(unf0),   32'(m_unf));
    chk("unf1",   32'(unf1),   32'(m_unf));
    chk("rd_valid0", 32'(rd_valid0), 32'(m_rv));
    chk("rd_data0",  32'(rd_data0),  32'(m_rd));
    chk("rd_valid1", 32'(rd_valid1), 32'(sz != 0));
    if (sz != 0) chk("rd_data1", 32'(rd_data1), 32'(q[0]));
  endtask

  // Inputs are driven at posedge+1; state is checked at the next posedge+1
  task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clear   = c;
    @(posedge clk);
    model_step(w, d, r, c);
    #1;
    check_model();
    wr_en = 1'b0;
    rd_en = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h33, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h44, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h55, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    chk("reset_rd_data0", 32'(rd_data0), 32'h0);
    reset = 1'b1;

    // Fill to full, thresholds along the way, then one overflowing write
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_af", 32'(af0), 32'(i >= 14));
    end
    chk("fill_full", 32'(full0), 32'h1);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf0), 32'h1);
    chk("ovf_level", 32'(level0), 32'd16);

    // Drain; registered read data appears one edge after rd_en
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_data", 32'(rd_data0), 32'(i));
      chk("drain_valid", 32'(rd_valid0), 32'h1);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_unf", 32'(unf0), 32'h1);
    chk("drain_empty", 32'(empty0), 32'h1);
    chk("drain_valid_off", 32'(rd_valid0), 32'h0);

    // Wrap: five rounds of 10 in / 10 out
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("wrap_level", 32'(level0), 32'h0);

    // Simultaneous access at level 5 and at full
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
    chk("simul5_level", 32'(level0), 32'd5);
    chk("simul5_ovf", 32'(ovf0), 32'h0);
    for (int i = 0; i < 11; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    chk("simul16_level", 32'(level0), 32'd15);
    chk("simul16_ovf", 32'(ovf0), 32'h1);

    // Table of single-cycle vectors starting from a flushed FIFO
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
      chk($sformatf("vec%0d_level", i), 32'(level0), 32'(vecs[i].exp_level));
      chk($sformatf("vec%0d_empty", i), 32'(empty0), 32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d_ovf", i),   32'(ovf0),   32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_unf", i),   32'(unf0),   32'(vecs[i].exp_unf));
    end

    // FWFT: word visible right after the writing edge
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("fwft_data", 32'(rd_data1), 32'hA5);
    chk("fwft_valid", 32'(rd_valid1), 32'h1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_empty", 32'(empty1), 32'h1);
    chk("fwft_valid_off", 32'(rd_valid1), 32'h0);

    // Flush at level 7 with a write pending
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("pre_clear_level", 32'(level0), 32'd7);
    cycle(1'b1, 8'h99, 1'b0, 1'b1);
    chk("clear_level", 32'(level0), 32'h0);
    chk("clear_empty", 32'(empty0), 32'h1);
    chk("clear_unf", 32'(unf0), 32'h0);
    chk("clear_rv", 32'(rd_valid0), 32'h0);

    // Asynchronous reset between edges during a burst
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'h5A;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_level", 32'(level0), 32'h0);
    chk("arst_empty", 32'(empty0), 32'h1);
    chk("arst_ae", 32'(ae0), 32'h1);
    chk("arst_full", 32'(full0), 32'h0);
    chk("arst_af", 32'(af0), 32'h0);
    chk("arst_ovf", 32'(ovf0), 32'h0);
    chk("arst_unf", 32'(unf0), 32'h0);
    chk("arst_rv0", 32'(rd_valid0), 32'h0);
    chk("arst_rd0", 32'(rd_data0), 32'h0);
    chk("arst_rv1", 32'(rd_valid1), 32'h0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_model();

    // Random traffic with occasional flushes
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 99) < 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous circular FIFO: next-generation buffer for same-clock producer/consumer paths, generalised in data width and depth. Adds correct simultaneous read/write at full and empty boundaries, almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 16, entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when level ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when level ≤ AE_LEVEL
- FWFT, 0, 0 = registered read (1-cycle latency), 1 = head word presented without a read request
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low
- clear  input  1  synchronous flush
- wr_en  input  1  write request
- wr_data  input  WIDTH  write data
- rd_en  input  1  read/pop request
- rd_data  output  WIDTH  read data
- rd_valid  output  1  rd_data holds a valid word
- full, empty  output  1  occupancy = DEPTH / 0
- almost_full, almost_empty  output  1  threshold flags
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow, underflow  output  1  sticky error flags

## Operation
- Pointers: $clog2(DEPTH) bits each, natural binary wrap DEPTH-1 → 0; no modulo logic.
- Write accepted (wr_acc) = wr_en & !full. Read accepted (rd_acc) = rd_en & !empty.
- Level: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. Never exceeds DEPTH or drops below 0.
- Simultaneous requests at full: read accepted, write rejected; overflow sets. At empty: write accepted, read rejected; underflow sets. No bypass from wr_data to rd_data.
- Flags decode from the registered level: full = (level==DEPTH), empty = (level==0), almost_full = (level≥AF_LEVEL), almost_empty = (level≤AE_LEVEL).
- overflow sets on wr_en & full. underflow sets on rd_en & empty. Both hold until clear or reset.
- FWFT=0: on rd_acc, rd_data ← mem[rd_ptr] and rd_valid pulses high for one cycle. Otherwise rd_data holds its value and rd_valid = 0.
- FWFT=1: rd_data = mem[rd_ptr] and rd_valid = !empty continuously. rd_en pops the head.
- clear has priority over wr_en/rd_en in the same cycle. It zeroes both pointers and level and clears overflow, underflow and rd_valid. Memory contents are not cleared.
- Reset (any time, including mid-transfer) sets rd_data=0, rd_valid=0, level=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, and both pointers to 0. Memory is not reset.

## Timing
- Write at edge N: level and flags update at edge N. In FWFT=1 mode, the word is visible on rd_data after edge N if the FIFO was empty.
- FWFT=0: rd_en high in cycle N with FIFO non-empty → rd_data/rd_valid valid after edge N+1 (1-cycle latency).
- Sustained wr_en+rd_en at 0 < level < DEPTH: one word in and one word out per cycle; level constant.
- Error flags assert at the edge that samples the offending request.

## Structure
- Package fifo_pkg: ptr_w(DEPTH) / level_w(DEPTH) width helper functions and a DEPTH power-of-two check, shared with future async FIFO variants.
- Sub-module fifo_mem_2p: WIDTH×DEPTH array with synchronous write port and asynchronous read port. The top level adds the output register for FWFT=0.
- Top level contains the pointer, level, flag and error logic.

## Test plan
- Reset, then write 0x1..0x10 (DEPTH=16, WIDTH=8) → full=1 and almost_full=1 from level 14; one further write sets overflow=1 and level stays 16.
- Drain the full FIFO with FWFT=0 → rd_data sequence 0x1..0x10, each one cycle after rd_en; 17th read sets underflow=1 and empty=1.
- Wrap test: 10 writes / 10 reads repeated 5 times → data order preserved across the pointer wrap; level returns to 0.
- Simultaneous wr_en+rd_en at level 0, 5 and 16 → level goes to 1, stays 5, and goes to 15 respectively; overflow/underflow set only at the boundaries.
- FWFT=1: write 0xA5 into an empty FIFO → rd_data=0xA5 and rd_valid=1 after the same edge; rd_en → empty=1.
- clear at level 7 with wr_en=1 asserted → level=0, empty=1, sticky flags 0, write ignored. Reset pulse mid-burst → all outputs take their reset values immediately.
